// File: rtl/ss_window_decoder.sv
// ss_window_decoder
// Converts a stream of unsigned stochastic-symbol products back to a binary
// value. Exactly 2^WIN_LOG2 accepted symbols are summed per window. The sum is
// rounded half-up, right-shifted by SHIFT and saturated to OUT_W bits. The
// result is then offered on a valid/ready handshake and held until the next
// window completes.
module ss_window_decoder #(
    parameter int SS_W     = 6,
    parameter int WIN_LOG2 = 8,
    parameter int SHIFT    = 4,
    parameter int OUT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SS_W-1:0]  ss_in,
    input  logic             ss_valid,
    output logic             ss_ready,
    output logic [OUT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow,
    output logic             busy
);

    // The accumulator cannot wrap inside one window: 2^WIN_LOG2 symbols of at
    // most 2^SS_W-1 each. One extra bit holds the final add, and the rounding
    // is done in a wider word so that the saturation compare never truncates.
    localparam int ACC_W  = SS_W + WIN_LOG2;
    localparam int SUM_W  = ACC_W + 1;
    localparam int WIDE_W = SUM_W + OUT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [WIN_LOG2-1:0] cnt_r;
    logic [OUT_W-1:0]   result_r;
    logic               result_valid_r;
    logic               overflow_r;

    logic [SUM_W-1:0]   sum_s;
    logic               last_cnt_s;
    logic [OUT_W:0]     rounded_s;

    // Round half up, shift, saturate; returns {overflow, value}.
    function automatic logic [OUT_W:0] round_sat(input logic [SUM_W-1:0] s);
        logic [WIDE_W-1:0] w;
        logic [WIDE_W-1:0] r;
        logic [WIDE_W-1:0] max_val;
        w       = {{OUT_W{1'b0}}, s} + (WIDE_W'(1'b1) << (SHIFT - 1));
        r       = w >> SHIFT;
        max_val = (WIDE_W'(1'b1) << OUT_W) - WIDE_W'(1'b1);
        if (r > max_val) begin
            return {1'b1, {OUT_W{1'b1}}};
        end else begin
            return {1'b0, r[OUT_W-1:0]};
        end
    endfunction

    // Running sum including the symbol on the input, final-count detect and rounded result.
    always_comb begin
        sum_s      = {1'b0, acc_r} + {{(SUM_W - SS_W){1'b0}}, ss_in};
        last_cnt_s = (cnt_r == {WIN_LOG2{1'b1}});
        rounded_s  = round_sat(sum_s);
    end

    // Handshake status decoded directly from the state.
    always_comb begin
        if (state_r == ACCUM) begin
            ss_ready = 1'b1;
            busy     = 1'b1;
        end else begin
            ss_ready = 1'b0;
            busy     = 1'b0;
        end
    end

    // Window state machine, accumulator and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            acc_r          <= {ACC_W{1'b0}};
            cnt_r          <= {WIN_LOG2{1'b0}};
            result_r       <= {OUT_W{1'b0}};
            result_valid_r <= 1'b0;
            overflow_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= ACCUM;
                        acc_r   <= {ACC_W{1'b0}};
                        cnt_r   <= {WIN_LOG2{1'b0}};
                    end
                end
                ACCUM: begin
                    // A restart discards any symbol presented in the same cycle,
                    // including the one that would have closed the window.
                    if (start) begin
                        acc_r <= {ACC_W{1'b0}};
                        cnt_r <= {WIN_LOG2{1'b0}};
                    end else if (ss_valid) begin
                        if (last_cnt_s) begin
                            result_r       <= rounded_s[OUT_W-1:0];
                            overflow_r     <= rounded_s[OUT_W];
                            result_valid_r <= 1'b1;
                            acc_r          <= {ACC_W{1'b0}};
                            cnt_r          <= {WIN_LOG2{1'b0}};
                            state_r        <= DONE;
                        end else begin
                            acc_r <= sum_s[ACC_W-1:0];
                            cnt_r <= cnt_r + {{(WIN_LOG2 - 1){1'b0}}, 1'b1};
                        end
                    end
                end
                DONE: begin
                    // Start is only honoured together with the draining handshake.
                    if (result_ready) begin
                        result_valid_r <= 1'b0;
                        if (start) begin
                            state_r <= ACCUM;
                            acc_r   <= {ACC_W{1'b0}};
                            cnt_r   <= {WIN_LOG2{1'b0}};
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r        <= IDLE;
                    result_valid_r <= 1'b0;
                    acc_r          <= {ACC_W{1'b0}};
                    cnt_r          <= {WIN_LOG2{1'b0}};
                end
            endcase
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_ss_window_decoder.sv
// Self-checking bench for ss_window_decoder. Two instances share all inputs:
// dut_a uses the default SHIFT=4 and dut_b uses SHIFT=3, which is the setting
// that can saturate. Expected results come from a table of window vectors and
// hand-written corner sequences. Each expected result is pushed to a
// scoreboard when its window is driven and popped when result_valid is seen.
module tb_ss_window_decoder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] ss_in;
    logic       ss_valid;
    logic       result_ready;

    logic       ss_ready_a, result_valid_a, overflow_a, busy_a;
    logic [9:0] result_a;
    logic       ss_ready_b, result_valid_b, overflow_b, busy_b;
    logic [9:0] result_b;

    ss_window_decoder #(.SS_W(6), .WIN_LOG2(8), .SHIFT(4), .OUT_W(10)) dut_a (
        .clk(clk), .rst(rst), .start(start), .ss_in(ss_in), .ss_valid(ss_valid),
        .ss_ready(ss_ready_a), .result(result_a), .result_valid(result_valid_a),
        .result_ready(result_ready), .overflow(overflow_a), .busy(busy_a)
    );

    ss_window_decoder #(.SS_W(6), .WIN_LOG2(8), .SHIFT(3), .OUT_W(10)) dut_b (
        .clk(clk), .rst(rst), .start(start), .ss_in(ss_in), .ss_valid(ss_valid),
        .ss_ready(ss_ready_b), .result(result_b), .result_valid(result_valid_b),
        .result_ready(result_ready), .overflow(overflow_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;   // nonzero symbol value
        int nz;    // first nz symbols carry val, the rest are 0
        bit tog;   // ss_valid low every other cycle; result held 5 cycles
        int exp_a; bit ovf_a;
        int exp_b; bit ovf_b;
    } vec_t;

    typedef struct {
        int ra; bit oa;
        int rb; bit ob;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_ra = 0;
    bit   last_oa = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int ra, input bit oa, input int rb, input bit ob);
        exp_t e;
        e.ra = ra; e.oa = oa; e.rb = rb; e.ob = ob;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_result_a"}, result_a, 0);
        chk({tag, "_valid_a"}, result_valid_a, 0);
        chk({tag, "_ovf_a"}, overflow_a, 0);
        chk({tag, "_ready_a"}, ss_ready_a, 0);
        chk({tag, "_busy_a"}, busy_a, 0);
        chk({tag, "_result_b"}, result_b, 0);
        chk({tag, "_ovf_b"}, overflow_b, 0);
        chk({tag, "_valid_b"}, result_valid_b, 0);
    endtask

    // Drives 256 accepted symbols; the window must not close before the last one.
    task automatic run_window(input int val, input int nz, input bit tog);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("valid_before_last", result_valid_a, 0);
                chk("busy_in_window", busy_a, 1);
            end
            if (tog) begin
                ss_valid = 1'b0;
                tick();
            end
            ss_in    = (i < nz) ? 6'(val) : 6'd0;
            ss_valid = 1'b1;
            tick();
        end
        ss_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the last symbol.
    task automatic check_result();
        exp_t e;
        chk("valid_latency_a", result_valid_a, 1);
        chk("valid_latency_b", result_valid_b, 1);
        chk("ready_low_done", ss_ready_a, 0);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow actual=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk("result_a", result_a, e.ra);
            chk("overflow_a", overflow_a, e.oa);
            chk("result_b", result_b, e.rb);
            chk("overflow_b", overflow_b, e.ob);
            last_ra = e.ra;
            last_oa = e.oa;
        end
    endtask

    task automatic deliver();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("valid_cleared", result_valid_a, 0);
        chk("idle_after_deliver", busy_a, 0);
        chk("result_held", result_a, last_ra);
    endtask

    task automatic collect(input int hold);
        check_result();
        for (int h = 0; h < hold; h++) begin
            ss_valid = 1'b1;
            ss_in    = 6'd63;
            tick();
            chk("hold_valid", result_valid_a, 1);
            chk("hold_ready_low", ss_ready_a, 0);
            chk("hold_result", result_a, last_ra);
        end
        ss_valid = 1'b0;
        deliver();
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{val: 49, nz: 256, tog: 1'b0, exp_a: 784,  ovf_a: 1'b0, exp_b: 1023, ovf_b: 1'b1};
        vecs[1] = '{val: 1,  nz: 8,   tog: 1'b0, exp_a: 1,    ovf_a: 1'b0, exp_b: 1,    ovf_b: 1'b0};
        vecs[2] = '{val: 1,  nz: 7,   tog: 1'b0, exp_a: 0,    ovf_a: 1'b0, exp_b: 1,    ovf_b: 1'b0};
        vecs[3] = '{val: 1,  nz: 256, tog: 1'b1, exp_a: 16,   ovf_a: 1'b0, exp_b: 32,   ovf_b: 1'b0};
        vecs[4] = '{val: 0,  nz: 256, tog: 1'b0, exp_a: 0,    ovf_a: 1'b0, exp_b: 0,    ovf_b: 1'b0};
        vecs[5] = '{val: 63, nz: 256, tog: 1'b0, exp_a: 1008, ovf_a: 1'b0, exp_b: 1023, ovf_b: 1'b1};
        vecs[6] = '{val: 0,  nz: 256, tog: 1'b0, exp_a: 0,    ovf_a: 1'b0, exp_b: 0,    ovf_b: 1'b0};
        vecs[7] = '{val: 1,  nz: 24,  tog: 1'b0, exp_a: 2,    ovf_a: 1'b0, exp_b: 3,    ovf_b: 1'b0};

        rst = 1'b0; start = 1'b0; ss_in = 6'd0; ss_valid = 1'b0; result_ready = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b1;
        tick();

        // Table-driven windows.
        for (int v = 0; v < 8; v++) begin
            pulse_start();
            chk("ready_after_start", ss_ready_a, 1);
            push_exp(vecs[v].exp_a, vecs[v].ovf_a, vecs[v].exp_b, vecs[v].ovf_b);
            run_window(vecs[v].val, vecs[v].nz, vecs[v].tog);
            collect(vecs[v].tog ? 5 : 0);
        end

        // Restart after 100 symbols; the symbol in the restart cycle is dropped.
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            ss_in = 6'd5; ss_valid = 1'b1;
            tick();
        end
        start = 1'b1; ss_in = 6'd63; ss_valid = 1'b1;
        tick();
        start = 1'b0; ss_valid = 1'b0;
        chk("busy_after_restart", busy_a, 1);
        push_exp(32, 1'b0, 64, 1'b0);
        run_window(2, 256, 1'b0);
        collect(0);

        // Start on the final-symbol cycle: restart wins and no result appears.
        pulse_start();
        for (int i = 0; i < 255; i++) begin
            ss_in = 6'd1; ss_valid = 1'b1;
            tick();
        end
        start = 1'b1; ss_in = 6'd1; ss_valid = 1'b1;
        tick();
        start = 1'b0; ss_valid = 1'b0;
        chk("final_restart_no_valid", result_valid_a, 0);
        chk("final_restart_busy", busy_a, 1);
        chk("final_restart_result", result_a, last_ra);
        chk("final_restart_ovf", overflow_a, last_oa);
        push_exp(48, 1'b0, 96, 1'b0);
        run_window(3, 256, 1'b0);
        collect(0);

        // Start in DONE is ignored until it coincides with result_ready.
        pulse_start();
        push_exp(64, 1'b0, 128, 1'b0);
        run_window(4, 256, 1'b0);
        check_result();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_ignored_valid", result_valid_a, 1);
        chk("done_start_ignored_busy", busy_a, 0);
        start = 1'b1; result_ready = 1'b1;
        tick();
        start = 1'b0; result_ready = 1'b0;
        chk("b2b_valid_cleared", result_valid_a, 0);
        chk("b2b_busy", busy_a, 1);
        push_exp(2, 1'b0, 3, 1'b0);
        run_window(1, 24, 1'b0);
        collect(0);

        // Asynchronous reset mid-window.
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            ss_in = 6'd9; ss_valid = 1'b1;
            tick();
        end
        ss_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero_outputs("rst_mid");
        #2 rst = 1'b1;
        tick();
        chk("idle_after_rst", busy_a, 0);

        // Asynchronous reset while a saturated result is pending in DONE.
        pulse_start();
        push_exp(1008, 1'b0, 1023, 1'b1);
        run_window(63, 256, 1'b0);
        check_result();
        #2 rst = 1'b0;
        #1 check_zero_outputs("rst_done");
        #2 rst = 1'b1;
        tick();

        pulse_start();
        push_exp(256, 1'b0, 512, 1'b0);
        run_window(16, 256, 1'b0);
        collect(0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
